fifo_ptr_ctrl: RTL and testbench

Pointer and flag controller for the small register-file FIFO. It sequences two wrap-around address counters (write and read) and gates write/read requests into memory enables. It produces full/empty/count status and sticky overflow/underflow error flags. It sits between the producer/consumer request lines and the FIFO storage array, replacing free-running counters with request-qualified ones.

---
 rtl/fifo_ptr_ctrl.sv | 68 ++++++
 tb/tb_fifo_ptr_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ptr_ctrl.sv
// Pointer and status controller for a small register-file FIFO.
// Gates requests into storage strobes and tracks occupancy plus sticky error flags.
module fifo_ptr_ctrl #(
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              clr_err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] rptr_q, rptr_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  // Status comes straight from the registered pointers; the MSB is the wrap bit.
  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) && (wptr_q[ADDR_W] != rptr_q[ADDR_W]);
    count = wptr_q - rptr_q;
  end

  // A read on a full FIFO frees a slot, so the write is accepted alongside it.
  // No fall-through: a read on an empty FIFO is rejected even with a concurrent write.
  always_comb begin
    rd_en = rd_req & ~empty & ~rst;
    wr_en = wr_req & (~full | rd_req) & ~rst;
  end

  always_comb begin
    wptr_d = wptr_q + {{ADDR_W{1'b0}}, wr_en};
    rptr_d = rptr_q + {{ADDR_W{1'b0}}, rd_en};
    // A new error event in the same cycle as clr_err keeps the flag set.
    ovf_d  = (ovf_q & ~clr_err) | (wr_req & ~wr_en);
    unf_d  = (unf_q & ~clr_err) | (rd_req & ~rd_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign wr_addr   = wptr_q[ADDR_W-1:0];
  assign rd_addr   = rptr_q[ADDR_W-1:0];
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed bench for fifo_ptr_ctrl (ADDR_W = 2): strobes, addresses, flags, wraps and reset.
`timescale 1ns/1ps
module tb_fifo_ptr_ctrl;

  localparam int unsigned ADDR_W = 2;

  logic              clk;
  logic              rst;
  logic              wr_req;
  logic              rd_req;
  logic              clr_err;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  int checks = 0;
  int errors = 0;

  fifo_ptr_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_req    (wr_req),
    .rd_req    (rd_req),
    .clr_err   (clr_err),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests at the falling edge, check strobes, then step past the rising edge.
  task automatic cyc(input logic w, input logic r, input logic c,
                     input logic exp_we, input logic exp_re, input string tag);
    @(negedge clk);
    wr_req  = w;
    rd_req  = r;
    clr_err = c;
    #1;
    chk({tag, ".wr_en"}, wr_en, exp_we);
    chk({tag, ".rd_en"}, rd_en, exp_re);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic f, input logic e,
                           input int wa, input int ra, input logic ov, input logic un);
    chk({tag, ".count"}, count, cnt);
    chk({tag, ".full"}, full, f);
    chk({tag, ".empty"}, empty, e);
    chk({tag, ".wr_addr"}, wr_addr, wa);
    chk({tag, ".rd_addr"}, rd_addr, ra);
    chk({tag, ".overflow"}, overflow, ov);
    chk({tag, ".underflow"}, underflow, un);
  endtask

  initial begin
    int mw;
    int mr;
    int cnt;
    logic w;
    logic r;
    logic exp_we;
    logic exp_re;

    // Reset with requests asserted: strobes must stay low and no error may latch.
    rst     = 1'b1;
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    clr_err = 1'b0;
    #1;
    chk("rst.wr_en", wr_en, 1'b0);
    chk("rst.rd_en", rd_en, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst    = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_state("reset_idle", 0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);

    // Fill: addresses 0..3, then full with wptr = 4.
    for (int i = 0; i < 4; i++) begin
      chk("fill.wr_addr", wr_addr, i);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "fill");
    end
    chk_state("full", 4, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "wr_full");
    chk_state("overflow", 4, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "clr_ovf");
    chk("clr_ovf.overflow", overflow, 1'b0);

    // Full with simultaneous read and write: both accepted, count holds.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "full_rw");
    chk_state("full_rw", 4, 1'b1, 1'b0, 1, 1, 1'b0, 1'b0);

    // Drain: read addresses 1,2,3,0.
    for (int i = 0; i < 4; i++) begin
      chk("drain.rd_addr", rd_addr, (1 + i) % 4);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "drain");
    end
    chk_state("drained", 0, 1'b0, 1'b1, 1, 1, 1'b0, 1'b0);

    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "rd_empty");
    chk_state("underflow", 0, 1'b0, 1'b1, 1, 1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "clr_unf");
    chk("clr_unf.underflow", underflow, 1'b0);

    // Clear and a new underflow in the same cycle: the set wins.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "clr_vs_set");
    chk("clr_vs_set.underflow", underflow, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "clr_unf2");
    chk("clr_unf2.underflow", underflow, 1'b0);

    // Empty with simultaneous read and write: only the write goes through.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "empty_rw");
    chk_state("empty_rw", 1, 1'b0, 1'b0, 2, 1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "clr_unf3");

    // Interleaved traffic across several pointer wraps against a reference occupancy model.
    mw = 6;
    mr = 5;
    for (int i = 0; i < 30; i++) begin
      w = (i % 3) != 2;
      r = (i % 2) == 1 || (i % 7) == 0;
      cnt = (mw - mr) & 7;
      exp_re = r && (cnt != 0);
      exp_we = w && ((cnt != 4) || r);
      cyc(w, r, 1'b0, exp_we, exp_re, "wrap");
      if (exp_we) mw = (mw + 1) % 8;
      if (exp_re) mr = (mr + 1) % 8;
      chk("wrap.count", count, (mw - mr) & 7);
      chk("wrap.wr_addr", wr_addr, mw % 4);
      chk("wrap.rd_addr", rd_addr, mr % 4);
    end

    // Bring occupancy to exactly 3 (bounded), then reset mid-operation.
    for (int i = 0; i < 8 && ((mw - mr) & 7) != 3; i++) begin
      if (((mw - mr) & 7) < 3) begin
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "to3_w");
        mw = (mw + 1) % 8;
      end else begin
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "to3_r");
        mr = (mr + 1) % 8;
      end
    end
    chk("pre_rst.count", count, 3);

    @(negedge clk);
    rst     = 1'b1;
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    clr_err = 1'b0;
    #1;
    chk("mid_rst.wr_en", wr_en, 1'b0);
    chk("mid_rst.rd_en", rd_en, 1'b0);
    @(posedge clk);
    #1;
    chk_state("mid_rst", 0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst    = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    @(posedge clk);
    #1;
    chk_state("post_rst", 0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
